nbody_pair_sequencer: RTL and testbench
=======================================

Name: nbody_pair_sequencer

Overview:
Parametrised control sequencer for the N-body accelerator. It generates the (i, j) body-pair read stream for the acceleration pipeline, with optional multiple i-lanes per pass. It tracks pipeline latency with a tagged delay line so accumulators get clear/valid/last strobes, then runs the position-update pass and repeats for a programmed number of timesteps. It sits between the bus register file (start/done handshake) and the body RAMs plus the getAccl/leapfrog datapath.

Parameters:
BODIES, 512, maximum body count; BODY_AW = $clog2(BODIES)
LANES, 1, i-bodies processed in parallel per j sweep (power of 2, 1..8)
ACCL_LATENCY, 125, cycles from pair issue to acceleration result valid (>=1)
UPD_LATENCY, 20, cycles from update read to write-back (>=1)
STEP_WIDTH, 32, width of timestep count

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begin run (ignored unless IDLE or DONE)
abort  in  1  level; cancel run, return to IDLE
num_bodies  in  BODY_AW+1  bodies in use (sampled on start)
num_steps  in  STEP_WIDTH  timesteps to run (sampled on start)
done_ack  in  1  software acknowledge; DONE->IDLE
busy  out  1  high in ACCEL/DRAIN_A/UPDATE/DRAIN_U
done  out  1  high only in DONE
pair_valid  out  1  i/j addresses valid this cycle
i_base  out  BODY_AW  first i-body of current lane group
j_addr  out  BODY_AW  current j body
lane_mask  out  LANES  bit k set if i_base+k < num_bodies
self_mask  out  LANES  bit k set if i_base+k == j_addr (datapath zeroes contribution)
acc_valid  out  1  pair_valid delayed ACCL_LATENCY
acc_first  out  1  delayed marker: j==0 for this group (clear accumulators)
acc_last  out  1  delayed marker: j==num_bodies-1 (commit velocity)
acc_i_base  out  BODY_AW  i_base delayed ACCL_LATENCY
acc_lane_mask  out  LANES  lane_mask delayed ACCL_LATENCY
upd_rd_valid  out  1  update-pass read strobe
upd_rd_addr  out  BODY_AW  update-pass read address
upd_wr_en  out  1  upd_rd_valid delayed UPD_LATENCY
upd_wr_addr  out  BODY_AW  upd_rd_addr delayed UPD_LATENCY
step_count  out  STEP_WIDTH  completed timesteps in current run

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; every output 0; delay lines cleared.
- States: IDLE, ACCEL, DRAIN_A, UPDATE, DRAIN_U, DONE.
- IDLE/DONE + start: latch num_bodies/num_steps; step_count<=0; i_base<=0, j_addr<=0. If num_bodies<2 or num_steps==0 go to DONE; else ACCEL next cycle.
- ACCEL: pair_valid=1 every cycle. j_addr increments; at j_addr==num_bodies-1, j_addr<=0 and i_base+=LANES. After the group with i_base+LANES>=num_bodies completes, go to DRAIN_A. Issue cycles = ceil(N/LANES)*N.
- DRAIN_A: exactly ACCL_LATENCY cycles, pair_valid=0; then UPDATE, upd_rd_addr<=0.
- UPDATE: upd_rd_valid=1 for N cycles, addresses 0..N-1; then DRAIN_U.
- DRAIN_U: exactly UPD_LATENCY cycles. Then step_count+=1; if new count==num_steps go to DONE, else go to ACCEL with i_base=j_addr=0.
- DONE: done=1 until done_ack (to IDLE) or start (new run). Both in the same cycle: start wins.
- Delay lines are pure shift registers. Outputs advance every cycle in all states, so acc_* and upd_wr_* complete in the drain states.
- abort (any busy state): IDLE next cycle, delay lines flushed (no acc_valid/upd_wr_en after), done stays 0, step_count holds.
- start while busy: ignored. num_bodies > BODIES: clamped to BODIES.
- Counters never wrap past num_bodies-1; all address arithmetic is BODY_AW bits, with i_base+k compared at BODY_AW+1 bits.

Optional Feature:
NBODY_SEQ_PERF_EN: adds output perf_cycles [31:0], which counts busy cycles of the current run (cleared on start, saturates at 2^32-1, holds in DONE/IDLE). Without the macro: no port, no counter.

Test Plan:
- N=4, LANES=1, ACCL_LATENCY=3, UPD_LATENCY=2, steps=1; start at cycle 0 -> pair_valid cycles 1..16 with (i,j)=(0,0),(0,1)..(3,3); self_mask=1 at i==j; acc_first at cycles 4,8,12,16; acc_last at 7,11,15,19; upd_rd_valid 20..23; upd_wr_en 22..25 addr 0..3; done=1 from cycle 26; step_count=1.
- N=5, LANES=4 -> two groups (i_base 0,4), 10 issue cycles; lane_mask=4'b1111 then 4'b0001.
- steps=3, N=2 -> step_count goes 1,2,3; done only after third DRAIN_U; ACCEL restarts with i_base=j_addr=0.
- abort asserted mid-ACCEL (N=8, cycle 10) -> busy=0 next cycle, no further acc_valid/upd_wr_en, done=0.
- num_bodies=1 or num_steps=0 -> done the cycle after start, no pair_valid; start and done_ack together in DONE -> new run begins.
- rst_n low for one cycle mid-UPDATE -> all outputs 0 next cycle, state IDLE; a later start runs normally.

Source files
------------

// File: rtl/nbody_pair_sequencer.sv
// rtl/nbody_pair_sequencer.sv - N-body (i,j) pair issue, drain, update and timestep sequencer (optional NBODY_SEQ_PERF_EN adds perf_cycles)
module nbody_pair_sequencer #(
    parameter int BODIES       = 512,
    parameter int LANES        = 1,
    parameter int ACCL_LATENCY = 125,
    parameter int UPD_LATENCY  = 20,
    parameter int STEP_WIDTH   = 32,
    localparam int BODY_AW     = $clog2(BODIES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [BODY_AW:0]      num_bodies,
    input  logic [STEP_WIDTH-1:0] num_steps,
    input  logic                  done_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  pair_valid,
    output logic [BODY_AW-1:0]    i_base,
    output logic [BODY_AW-1:0]    j_addr,
    output logic [LANES-1:0]      lane_mask,
    output logic [LANES-1:0]      self_mask,
    output logic                  acc_valid,
    output logic                  acc_first,
    output logic                  acc_last,
    output logic [BODY_AW-1:0]    acc_i_base,
    output logic [LANES-1:0]      acc_lane_mask,
    output logic                  upd_rd_valid,
    output logic [BODY_AW-1:0]    upd_rd_addr,
    output logic                  upd_wr_en,
    output logic [BODY_AW-1:0]    upd_wr_addr,
    output logic [STEP_WIDTH-1:0] step_count
`ifdef NBODY_SEQ_PERF_EN
    ,
    output logic [31:0]           perf_cycles
`endif
);

    localparam logic [BODY_AW:0] BODIES_W = (BODY_AW+1)'(BODIES);
    localparam logic [BODY_AW:0] LANES_W  = (BODY_AW+1)'(LANES);
    localparam int ACC_W = 3 + BODY_AW + LANES;
    localparam int UPD_W = 1 + BODY_AW;

    typedef enum logic [2:0] {
        S_IDLE, S_ACCEL, S_DRAIN_A, S_UPDATE, S_DRAIN_U, S_DONE
    } state_t;

    state_t                state, state_nxt;
    logic [BODY_AW:0]      nb_q;
    logic [STEP_WIDTH-1:0] steps_q;
    logic [31:0]           drain_cnt;
    logic [BODY_AW:0]      nb_clamped;
    logic                  start_ok, abort_ok;
    logic                  j_last, grp_last, upd_last, drain_a_last, drain_u_last, run_last;

    assign nb_clamped   = (num_bodies > BODIES_W) ? BODIES_W : num_bodies;
    assign start_ok     = start && (state == S_IDLE || state == S_DONE);
    assign abort_ok     = abort && busy;
    assign j_last       = ({1'b0, j_addr} == nb_q - (BODY_AW+1)'(1));
    assign grp_last     = ({1'b0, i_base} + LANES_W) >= nb_q;
    assign upd_last     = ({1'b0, upd_rd_addr} == nb_q - (BODY_AW+1)'(1));
    assign drain_a_last = (drain_cnt == 32'(ACCL_LATENCY - 1));
    assign drain_u_last = (drain_cnt == 32'(UPD_LATENCY - 1));
    assign run_last     = (step_count + STEP_WIDTH'(1)) == steps_q;

    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        done         = 1'b0;
        pair_valid   = 1'b0;
        upd_rd_valid = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (start_ok)
                    state_nxt = (nb_clamped < (BODY_AW+1)'(2) || num_steps == '0) ? S_DONE : S_ACCEL;
                else if (state == S_DONE && done_ack)
                    state_nxt = S_IDLE;
            end
            S_ACCEL: begin
                busy       = 1'b1;
                pair_valid = 1'b1;
                if (j_last && grp_last) state_nxt = S_DRAIN_A;
            end
            S_DRAIN_A: begin
                busy = 1'b1;
                if (drain_a_last) state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                busy         = 1'b1;
                upd_rd_valid = 1'b1;
                if (upd_last) state_nxt = S_DRAIN_U;
            end
            S_DRAIN_U: begin
                busy = 1'b1;
                if (drain_u_last) state_nxt = run_last ? S_DONE : S_ACCEL;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort_ok) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            nb_q        <= '0;
            steps_q     <= '0;
            step_count  <= '0;
            i_base      <= '0;
            j_addr      <= '0;
            upd_rd_addr <= '0;
            drain_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                drain_cnt <= '0;
            else if (state == S_DRAIN_A || state == S_DRAIN_U)
                drain_cnt <= drain_cnt + 32'd1;

            if (start_ok) begin
                nb_q       <= nb_clamped;
                steps_q    <= num_steps;
                step_count <= '0;
                i_base     <= '0;
                j_addr     <= '0;
            end else if (!abort_ok) begin
                case (state)
                    S_ACCEL: begin
                        if (j_last) begin
                            j_addr <= '0;
                            if (!grp_last) i_base <= i_base + BODY_AW'(LANES);
                        end else begin
                            j_addr <= j_addr + BODY_AW'(1);
                        end
                    end
                    S_DRAIN_A: if (drain_a_last) upd_rd_addr <= '0;
                    S_UPDATE:  if (!upd_last) upd_rd_addr <= upd_rd_addr + BODY_AW'(1);
                    S_DRAIN_U: begin
                        if (drain_u_last) begin
                            step_count <= step_count + STEP_WIDTH'(1);
                            i_base     <= '0;
                            j_addr     <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Lane k covers body i_base+k; widened by one bit so the last group cannot alias.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [BODY_AW:0] lane_ix;
        assign lane_ix      = {1'b0, i_base} + (BODY_AW+1)'(k);
        assign lane_mask[k] = pair_valid && (lane_ix < nb_q);
        assign self_mask[k] = pair_valid && (lane_ix == {1'b0, j_addr});
    end

    logic [ACC_W-1:0] acc_line [ACCL_LATENCY];
    logic [UPD_W-1:0] upd_line [UPD_LATENCY];
    logic [ACC_W-1:0] acc_in;
    logic [UPD_W-1:0] upd_in;

    assign acc_in = {pair_valid, pair_valid && (j_addr == '0), pair_valid && j_last,
                     pair_valid ? i_base : '0, lane_mask};
    assign upd_in = {upd_rd_valid, upd_rd_valid ? upd_rd_addr : '0};

    // Flushing on abort keeps stale strobes from reaching the datapath after cancel.
    always_ff @(posedge clk) begin
        if (!rst_n || abort_ok) begin
            for (int k = 0; k < ACCL_LATENCY; k++) acc_line[k] <= '0;
            for (int k = 0; k < UPD_LATENCY; k++)  upd_line[k] <= '0;
        end else begin
            acc_line[0] <= acc_in;
            upd_line[0] <= upd_in;
            for (int k = 1; k < ACCL_LATENCY; k++) acc_line[k] <= acc_line[k-1];
            for (int k = 1; k < UPD_LATENCY; k++)  upd_line[k] <= upd_line[k-1];
        end
    end

    assign {acc_valid, acc_first, acc_last, acc_i_base, acc_lane_mask} = acc_line[ACCL_LATENCY-1];
    assign {upd_wr_en, upd_wr_addr} = upd_line[UPD_LATENCY-1];

`ifdef NBODY_SEQ_PERF_EN
    logic [31:0] perf_q;
    always_ff @(posedge clk) begin
        if (!rst_n)
            perf_q <= '0;
        else if (start_ok)
            perf_q <= '0;
        else if (busy && perf_q != 32'hFFFF_FFFF)
            perf_q <= perf_q + 32'd1;
    end
    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_nbody_pair_sequencer.sv
// tb/tb_nbody_pair_sequencer.sv - self-checking bench for nbody_pair_sequencer (LANES=1 and LANES=4 instances)
module tb_nbody_pair_sequencer;
    localparam int AL = 3;
    localparam int UL = 2;

    logic clk = 1'b0;
    logic rst_n, start1, start4, abort, done_ack;
    logic [4:0] nbodies;
    logic [7:0] nsteps;

    logic       d1_busy, d1_done, d1_pv, d1_av, d1_af, d1_alast, d1_rd, d1_wr;
    logic [3:0] d1_ib, d1_j, d1_aib, d1_rda, d1_wra;
    logic [0:0] d1_lm, d1_sm, d1_alm;
    logic [7:0] d1_step;
    logic       d4_busy, d4_done, d4_pv, d4_av, d4_af, d4_alast, d4_rd, d4_wr;
    logic [3:0] d4_ib, d4_j, d4_aib, d4_rda, d4_wra;
    logic [3:0] d4_lm, d4_sm, d4_alm;
    logic [7:0] d4_step;

    nbody_pair_sequencer #(.BODIES(16), .LANES(1), .ACCL_LATENCY(AL), .UPD_LATENCY(UL), .STEP_WIDTH(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .num_bodies(nbodies),
        .num_steps(nsteps), .done_ack(done_ack), .busy(d1_busy), .done(d1_done),
        .pair_valid(d1_pv), .i_base(d1_ib), .j_addr(d1_j), .lane_mask(d1_lm), .self_mask(d1_sm),
        .acc_valid(d1_av), .acc_first(d1_af), .acc_last(d1_alast), .acc_i_base(d1_aib),
        .acc_lane_mask(d1_alm), .upd_rd_valid(d1_rd), .upd_rd_addr(d1_rda), .upd_wr_en(d1_wr),
        .upd_wr_addr(d1_wra), .step_count(d1_step));

    nbody_pair_sequencer #(.BODIES(16), .LANES(4), .ACCL_LATENCY(AL), .UPD_LATENCY(UL), .STEP_WIDTH(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort), .num_bodies(nbodies),
        .num_steps(nsteps), .done_ack(done_ack), .busy(d4_busy), .done(d4_done),
        .pair_valid(d4_pv), .i_base(d4_ib), .j_addr(d4_j), .lane_mask(d4_lm), .self_mask(d4_sm),
        .acc_valid(d4_av), .acc_first(d4_af), .acc_last(d4_alast), .acc_i_base(d4_aib),
        .acc_lane_mask(d4_alm), .upd_rd_valid(d4_rd), .upd_rd_addr(d4_rda), .upd_wr_en(d4_wr),
        .upd_wr_addr(d4_wra), .step_count(d4_step));

    always #5 clk = ~clk;

    logic sel4 = 1'b0;
    logic       s_busy, s_done, s_pv, s_av, s_af, s_alast, s_rd, s_wr;
    logic [3:0] s_ib, s_j, s_aib, s_rda, s_wra, s_lm, s_sm, s_alm;
    logic [7:0] s_step;
    assign s_busy  = sel4 ? d4_busy  : d1_busy;
    assign s_done  = sel4 ? d4_done  : d1_done;
    assign s_pv    = sel4 ? d4_pv    : d1_pv;
    assign s_av    = sel4 ? d4_av    : d1_av;
    assign s_af    = sel4 ? d4_af    : d1_af;
    assign s_alast = sel4 ? d4_alast : d1_alast;
    assign s_rd    = sel4 ? d4_rd    : d1_rd;
    assign s_wr    = sel4 ? d4_wr    : d1_wr;
    assign s_ib    = sel4 ? d4_ib    : d1_ib;
    assign s_j     = sel4 ? d4_j     : d1_j;
    assign s_aib   = sel4 ? d4_aib   : d1_aib;
    assign s_rda   = sel4 ? d4_rda   : d1_rda;
    assign s_wra   = sel4 ? d4_wra   : d1_wra;
    assign s_lm    = sel4 ? d4_lm    : {3'b000, d1_lm};
    assign s_sm    = sel4 ? d4_sm    : {3'b000, d1_sm};
    assign s_alm   = sel4 ? d4_alm   : {3'b000, d1_alm};
    assign s_step  = sel4 ? d4_step  : d1_step;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int mode = 0;
    int start_cyc = 0;
    int m_n = 1, m_lanes = 1, m_steps = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Closed-form schedule: one timestep = issue + accel drain + update + update drain.
    task automatic model_check(input int c);
        int n, lw, a, p, s, r, ra, rr, rw, ib, jj;
        logic [3:0] lm, sm;
        n  = (m_n < 1) ? 1 : m_n;
        lw = m_lanes;
        a  = ((n + lw - 1) / lw) * n;
        p  = a + AL + n + UL;
        s  = (c - 1) / p;
        r  = (c - 1) % p;
        if (s >= m_steps) begin
            chk("busy", s_busy, 0); chk("done", s_done, 1); chk("step_count", s_step, m_steps);
            chk("pair_valid", s_pv, 0); chk("acc_valid", s_av, 0);
            chk("upd_rd_valid", s_rd, 0); chk("upd_wr_en", s_wr, 0);
        end else begin
            chk("busy", s_busy, 1); chk("done", s_done, 0); chk("step_count", s_step, s);
            chk("pair_valid", s_pv, r < a);
            if (r < a) begin
                ib = (r / n) * lw; jj = r % n; lm = '0; sm = '0;
                for (int k = 0; k < lw; k++) begin
                    if (ib + k < n) lm[k] = 1'b1;
                    if (ib + k == jj) sm[k] = 1'b1;
                end
                chk("i_base", s_ib, ib); chk("j_addr", s_j, jj);
                chk("lane_mask", s_lm, lm); chk("self_mask", s_sm, sm);
            end
            ra = r - AL;
            chk("acc_valid", s_av, ra >= 0 && ra < a);
            chk("acc_first", s_af, ra >= 0 && ra < a && ra % n == 0);
            chk("acc_last", s_alast, ra >= 0 && ra < a && ra % n == n - 1);
            if (ra >= 0 && ra < a) begin
                ib = (ra / n) * lw; lm = '0;
                for (int k = 0; k < lw; k++) if (ib + k < n) lm[k] = 1'b1;
                chk("acc_i_base", s_aib, ib); chk("acc_lane_mask", s_alm, lm);
            end
            rr = r - a - AL;
            chk("upd_rd_valid", s_rd, rr >= 0 && rr < n);
            if (rr >= 0 && rr < n) chk("upd_rd_addr", s_rda, rr);
            rw = rr - UL;
            chk("upd_wr_en", s_wr, rw >= 0 && rw < n);
            if (rw >= 0 && rw < n) chk("upd_wr_addr", s_wra, rw);
        end
    endtask

    always @(negedge clk) begin
        if (mode == 1 && cyc - start_cyc >= 1) begin
            model_check(cyc - start_cyc);
        end else if (mode == 2) begin
            chk("abort_busy", s_busy, 0); chk("abort_done", s_done, 0);
            chk("abort_acc_valid", s_av, 0); chk("abort_upd_wr_en", s_wr, 0);
            chk("abort_pair_valid", s_pv, 0);
        end
    end

    task automatic do_start(input bit use4, input int n, input int st, input bit ack);
        @(posedge clk); #1;
        sel4 = use4; nbodies = n[4:0]; nsteps = st[7:0]; done_ack = ack;
        if (use4) start4 = 1'b1; else start1 = 1'b1;
        m_n = (n > 16) ? 16 : n; m_lanes = use4 ? 4 : 1;
        m_steps = (m_n < 2 || st == 0) ? 0 : st;
        start_cyc = cyc; mode = 1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0; done_ack = 1'b0;
    endtask

    task automatic wait_c(input int c);
        while (cyc - start_cyc < c) begin @(posedge clk); #1; end
        @(negedge clk);
    endtask

    task automatic wait_done(input int lim);
        int k = 0;
        while (!s_done && k < lim) begin @(posedge clk); #1; k++; end
        chk("done_reached", s_done, 1);
    endtask

    task automatic ack_done();
        mode = 0;
        @(posedge clk); #1; done_ack = 1'b1;
        @(posedge clk); #1; done_ack = 1'b0;
        chk("ack_to_idle", s_done, 0);
    endtask

    initial begin
        rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0; abort = 1'b0; done_ack = 1'b0;
        nbodies = '0; nsteps = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", d1_busy, 0); chk("rst_done", d1_done, 0); chk("rst_pv", d1_pv, 0);
        chk("rst_acc_valid", d1_av, 0); chk("rst_upd_wr_en", d1_wr, 0);
        chk("rst_step", d1_step, 0); chk("rst_lane_mask4", d4_lm, 0); chk("rst_ib4", d4_ib, 0);
        rst_n = 1'b1;

        // N=4, LANES=1, one step
        do_start(0, 4, 1, 0);
        wait_c(1);  chk("A_pv1", s_pv, 1); chk("A_i1", s_ib, 0); chk("A_j1", s_j, 0);
        wait_c(4);  chk("A_first4", s_af, 1);
        wait_c(7);  chk("A_last7", s_alast, 1);
        wait_c(16); chk("A_i16", s_ib, 3); chk("A_j16", s_j, 3); chk("A_self16", s_sm, 1);
        wait_c(20); chk("A_rd20", s_rd, 1); chk("A_rda20", s_rda, 0);
        wait_c(25); chk("A_wr25", s_wr, 1); chk("A_wra25", s_wra, 3);
        wait_c(26); chk("A_done26", s_done, 1); chk("A_step26", s_step, 1);
        ack_done();

        // N=5, LANES=4: two groups
        do_start(1, 5, 1, 0);
        wait_c(1);  chk("B_lm1", s_lm, 4'b1111); chk("B_i1", s_ib, 0);
        wait_c(6);  chk("B_lm6", s_lm, 4'b0001); chk("B_i6", s_ib, 4); chk("B_j6", s_j, 0);
        wait_c(10); chk("B_j10", s_j, 4); chk("B_self10", s_sm, 4'b0001);
        wait_c(11); chk("B_pv11", s_pv, 0);
        wait_done(100);
        ack_done();

        // N=2, three steps, then start+ack together from DONE
        do_start(0, 2, 3, 0);
        wait_c(12); chk("C_step12", s_step, 1); chk("C_pv12", s_pv, 1); chk("C_i12", s_ib, 0);
        wait_c(23); chk("C_step23", s_step, 2);
        wait_c(33); chk("C_done33", s_done, 0);
        wait_c(34); chk("C_done34", s_done, 1); chk("C_step34", s_step, 3);
        do_start(0, 2, 1, 1);
        wait_c(1);  chk("C2_busy1", s_busy, 1);
        wait_c(12); chk("C2_done12", s_done, 1); chk("C2_step12", s_step, 1);
        ack_done();

        // degenerate runs
        do_start(0, 1, 5, 0);
        wait_c(1);  chk("D_done1", s_done, 1); chk("D_pv1", s_pv, 0);
        do_start(0, 4, 0, 1);
        wait_c(1);  chk("D2_done1", s_done, 1);
        ack_done();

        // abort mid-ACCEL
        do_start(0, 8, 1, 0);
        wait_c(10); abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0; mode = 2;
        chk("E_busy11", s_busy, 0);
        repeat (20) @(posedge clk);
        #1; mode = 0;
        chk("E_step_hold", s_step, 0);

        // reset mid-UPDATE, then a normal run
        do_start(0, 4, 1, 0);
        wait_c(21); rst_n = 1'b0;
        @(posedge clk); #1; mode = 0;
        chk("F_busy", s_busy, 0); chk("F_rd", s_rd, 0); chk("F_wr", s_wr, 0);
        chk("F_pv", s_pv, 0); chk("F_av", s_av, 0); chk("F_done", s_done, 0);
        chk("F_rda", s_rda, 0); chk("F_wra", s_wra, 0);
        rst_n = 1'b1;
        do_start(0, 3, 2, 0);
        wait_done(200);
        mode = 0;
        chk("F2_step", s_step, 2);
        ack_done();

        // num_bodies above BODIES clamps to 16
        do_start(1, 20, 1, 0);
        wait_c(64); chk("G_i64", s_ib, 12); chk("G_j64", s_j, 15);
        wait_c(86); chk("G_done86", s_done, 1);
        ack_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
